// File: rtl/shift_sequencer_pkg.sv
// Shared encodings for the shift sequencer: op codes, shifter commands,
// mux select codes and FSM states.
package shift_seq_defs;

  localparam logic [2:0] OP_SLL  = 3'd0;
  localparam logic [2:0] OP_SRL  = 3'd1;
  localparam logic [2:0] OP_SRA  = 3'd2;
  localparam logic [2:0] OP_SLLV = 3'd3;
  localparam logic [2:0] OP_SRAV = 3'd4;
  localparam logic [2:0] OP_SLLM = 3'd5;

  localparam logic [2:0] CMD_HOLD    = 3'b000;
  localparam logic [2:0] CMD_LOAD    = 3'b001;
  localparam logic [2:0] CMD_LEFT    = 3'b010;
  localparam logic [2:0] CMD_RIGHT_L = 3'b011;
  localparam logic [2:0] CMD_RIGHT_A = 3'b100;

  localparam logic [1:0] SHN_B   = 2'd0;
  localparam logic [1:0] SHN_IMM = 2'd1;
  localparam logic [1:0] SHN_MEM = 2'd2;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

endpackage

// File: rtl/shift_op_decode.sv
// Pure decode of a shift op into legality, mux selects and the shifter
// command used during the SHIFT state.
module shift_op_decode
  import shift_seq_defs::*;
(
  input  logic [2:0] op_i,
  output logic       legal_o,
  output logic [1:0] n_ctrl_o,
  output logic       src_ctrl_o,
  output logic [2:0] cmd_o
);

  always_comb begin
    legal_o    = 1'b1;
    n_ctrl_o   = SHN_B;
    src_ctrl_o = SRC_A;
    cmd_o      = CMD_HOLD;
    case (op_i)
      OP_SLL: begin
        n_ctrl_o   = SHN_IMM;
        src_ctrl_o = SRC_B;
        cmd_o      = CMD_LEFT;
      end
      OP_SRL: begin
        n_ctrl_o   = SHN_IMM;
        src_ctrl_o = SRC_B;
        cmd_o      = CMD_RIGHT_L;
      end
      OP_SRA: begin
        n_ctrl_o   = SHN_IMM;
        src_ctrl_o = SRC_B;
        cmd_o      = CMD_RIGHT_A;
      end
      OP_SLLV: begin
        n_ctrl_o   = SHN_B;
        src_ctrl_o = SRC_A;
        cmd_o      = CMD_LEFT;
      end
      OP_SRAV: begin
        n_ctrl_o   = SHN_B;
        src_ctrl_o = SRC_A;
        cmd_o      = CMD_RIGHT_A;
      end
      OP_SLLM: begin
        n_ctrl_o   = SHN_MEM;
        src_ctrl_o = SRC_B;
        cmd_o      = CMD_LEFT;
      end
      default: legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multicycle controller driving the shift-amount mux and the shift register:
// IDLE -> LOAD -> (SHIFT) -> WRITE, with registered outputs throughout.
module shift_sequencer
  import shift_seq_defs::*;
#(
  parameter int N_WIDTH   = 5,
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [N_WIDTH-1:0] shift_n,
  output logic [1:0]         shift_n_ctrl,
  output logic               shift_src_ctrl,
  output logic [2:0]         shift_ctrl,
  output logic               reg_write,
  output logic               busy,
  output logic               done,
  output logic               illegal,
  output logic [N_WIDTH-1:0] shift_amt
);

  state_e               state_q;
  logic [2:0]           op_q;
  logic [N_WIDTH-1:0]   n_q;
  logic [1:0]           shift_n_ctrl_q;
  logic                 shift_src_ctrl_q;
  logic [2:0]           shift_ctrl_q;
  logic                 reg_write_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 illegal_q;

  logic [2:0]           dec_op_d;
  logic                 dec_legal;
  logic [1:0]           dec_n_ctrl;
  logic                 dec_src_ctrl;
  logic [2:0]           dec_cmd;

  // In IDLE the decoder looks at the incoming op (to accept/reject it and
  // preload the selects); once busy it decodes the captured op_q.
  assign dec_op_d = (state_q == ST_IDLE) ? op : op_q;

  shift_op_decode u_decode (
    .op_i       (dec_op_d),
    .legal_o    (dec_legal),
    .n_ctrl_o   (dec_n_ctrl),
    .src_ctrl_o (dec_src_ctrl),
    .cmd_o      (dec_cmd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      op_q             <= '0;
      n_q              <= '0;
      shift_n_ctrl_q   <= SHN_B;
      shift_src_ctrl_q <= SRC_A;
      shift_ctrl_q     <= CMD_HOLD;
      reg_write_q      <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      illegal_q        <= 1'b0;
    end else begin
      reg_write_q <= 1'b0;
      done_q      <= 1'b0;
      illegal_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          shift_ctrl_q <= CMD_HOLD;
          if (start) begin
            if (dec_legal) begin
              state_q          <= ST_LOAD;
              op_q             <= op;
              shift_ctrl_q     <= CMD_LOAD;
              shift_n_ctrl_q   <= dec_n_ctrl;
              shift_src_ctrl_q <= dec_src_ctrl;
              busy_q           <= 1'b1;
            end else begin
              illegal_q <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          n_q <= shift_n;
          // A zero amount leaves the loaded value untouched, so go straight to write-back.
          if (SKIP_ZERO && (shift_n == '0)) begin
            state_q      <= ST_WRITE;
            shift_ctrl_q <= CMD_HOLD;
            reg_write_q  <= 1'b1;
            done_q       <= 1'b1;
          end else begin
            state_q      <= ST_SHIFT;
            shift_ctrl_q <= dec_cmd;
          end
        end
        ST_SHIFT: begin
          state_q      <= ST_WRITE;
          shift_ctrl_q <= CMD_HOLD;
          reg_write_q  <= 1'b1;
          done_q       <= 1'b1;
        end
        ST_WRITE: begin
          state_q          <= ST_IDLE;
          shift_ctrl_q     <= CMD_HOLD;
          shift_n_ctrl_q   <= SHN_B;
          shift_src_ctrl_q <= SRC_A;
          busy_q           <= 1'b0;
        end
        default: begin
          state_q          <= ST_IDLE;
          shift_ctrl_q     <= CMD_HOLD;
          shift_n_ctrl_q   <= SHN_B;
          shift_src_ctrl_q <= SRC_A;
          busy_q           <= 1'b0;
        end
      endcase
    end
  end

  assign shift_n_ctrl   = shift_n_ctrl_q;
  assign shift_src_ctrl = shift_src_ctrl_q;
  assign shift_ctrl     = shift_ctrl_q;
  assign reg_write      = reg_write_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign illegal        = illegal_q;
  assign shift_amt      = n_q;

endmodule
